face_packet_receiver: RTL
=========================

Name: face_packet_receiver

Overview:
- Host-side initiator of the camera-to-software face handshake; replaces the software end so the on-chip solver can pull face data directly.
- On start it requests a capture, then pulls 10 words from the camera-side responder: face number, then Color1..Color9.
- Captured words are held in a 10-entry register file with a random-access read port.
- Sits between the camera-side responder and the solver datapath, on the same clock as both.

Parameters:
- TIMEOUT_CYCLES, 2**20, maximum cycles spent in any wait state before aborting with timeout_err.
- WORD_W, 30, port/word width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a capture when in IDLE, ignored otherwise.
- abort  in  1  returns to IDLE from any state next cycle; to_hw_sig=0.
- to_sw_sig  in  2  responder status: 3 reset, 0 idle/acked, 1 busy or word valid, 2 capture ready.
- to_sw_port  in  WORD_W  responder data word.
- to_hw_sig  out  2  command: 0 idle, 3 start capture, 1 request word, 2 acknowledge.
- to_hw_port  out  WORD_W  always 0; reserved.
- rd_idx  in  4  register-file read index 0..9; 10..15 read as 0.
- rd_data  out  WORD_W  combinational read of word[rd_idx].
- face_num  out  6  word[0][5:0].
- packet_valid  out  1  high from DONE until the next start, abort or Reset.
- busy  out  1  high in every state except IDLE, DONE, ERR.
- timeout_err  out  1  sticky; cleared by start or Reset.
- fmt_err  out  1  set in DONE if word[0][29:6]!=0; cleared by start.

Behaviour:
- Reset values: all outputs 0, all words 0, state IDLE, idx 0, watchdog 0.
- Outputs are registered from state. Responder inputs are sampled on Clk with no synchronizer, because both ends share the clock.
- IDLE: to_hw_sig=0. On start: clear packet_valid, timeout_err, fmt_err and idx, then go to START.
- START: to_hw_sig=3. Go to REQ when to_sw_sig==2.
  - to_sw_sig==1 here means the responder is still busy; keep waiting.
  - to_sw_sig==3 (responder in reset): keep waiting.
- REQ: to_hw_sig=1. When to_sw_sig==1, capture word[idx]<=to_sw_port and go to ACK. The capture uses the same edge that sees sig==1.
- ACK: to_hw_sig=2. When to_sw_sig==0:
  - idx==9: go to RELEASE.
  - otherwise: idx<=idx+1 and go to REQ.
- RELEASE: to_hw_sig=1 for exactly one cycle, which returns the responder to its idle wait. Then go to DONE.
- DONE: to_hw_sig=0, packet_valid=1, fmt_err evaluated. start begins a new capture; words are overwritten progressively.
- ERR: to_hw_sig=0, timeout_err=1. Leave only via start (to START) or abort (to IDLE).
- Watchdog: counts cycles in START, REQ and ACK, and resets to 0 on every state change. At count==TIMEOUT_CYCLES-1 go to ERR.
- Latency: minimum capture time with an immediately responding partner is about 2 cycles per word plus 3 overhead (≈23 cycles).
- Simultaneous events:
  - abort beats a watchdog expiry and any handshake advance.
  - start while busy is ignored.
- Unexpected responses:
  - to_sw_sig==3 in REQ or ACK (responder reset mid-packet): go to ERR immediately and set timeout_err.
  - to_sw_sig==2 in ACK: keep waiting.
- Reset mid-operation: asynchronous clear to IDLE; partial words are lost.
- idx is 4 bits and never exceeds 9; there is no wrap.

Decomposition:
- Package face_link_pkg:
  - sig encodings SIG_IDLE=0, SIG_REQ=1, SIG_ACK=2, SIG_START=3;
  - NUM_WORDS=10;
  - rx_state_t enum {IDLE, START, REQ, ACK, RELEASE, DONE, ERR}.
- Sub-module face_rx_watchdog: a parameterised counter with clear and expire outputs.
- The register file stays inline.

Test Plan:
- Nominal: pair with the camera-side responder model holding FaceNum=6'd5 and ColorN=30'h100+N; pulse start. Required: packet_valid rises; rd_data(0)=5 and rd_data(9)=30'h109; face_num=5; the responder is back in its idle wait; to_hw_sig=0.
- Slow ready: responder ready delayed 500 cycles. Required: to_hw_sig held at 3 throughout, no timeout, packet completes.
- Timeout: TIMEOUT_CYCLES=16, responder never leaves sig 0 in REQ. Required: ERR 16 cycles after entering REQ; timeout_err=1; to_hw_sig=0; a later start clears timeout_err.
- Abort during word 4 ACK. Required: next cycle IDLE, to_hw_sig=0, packet_valid=0, words 0..4 retained.
- Format: word0=30'h40. Required: fmt_err=1 in DONE and face_num=0.
- Async reset mid-REQ, then start. Required: immediate zero outputs, then a clean full capture.

Source files
------------

// File: rtl/face_link_pkg.sv
// Shared encodings for the camera/host face handshake: command/status codes,
// packet length and the receiver state type.
package face_link_pkg;

    localparam logic [1:0] SIG_IDLE  = 2'd0;
    localparam logic [1:0] SIG_REQ   = 2'd1;
    localparam logic [1:0] SIG_ACK   = 2'd2;
    localparam logic [1:0] SIG_START = 2'd3;

    localparam int NUM_WORDS = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        REQ,
        ACK,
        RELEASE,
        DONE,
        ERR
    } rx_state_t;

endpackage

// File: rtl/face_rx_watchdog.sv
// Wait-state watchdog: counts cycles while run is high, restarts on clear,
// and flags expiry on the last allowed cycle so the FSM can leave on that edge.
module face_rx_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expire = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/face_packet_receiver.sv
// Host-side initiator of the face handshake: requests a capture, pulls ten
// words from the camera-side responder and holds them for random-access reads.
module face_packet_receiver
    import face_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int WORD_W         = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        to_sw_sig,
    input  logic [WORD_W-1:0] to_sw_port,
    output logic [1:0]        to_hw_sig,
    output logic [WORD_W-1:0] to_hw_port,
    input  logic [3:0]        rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic [5:0]        face_num,
    output logic              packet_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic              fmt_err,
    output rx_state_t         state
);

    // Handshake: each level of to_hw_sig is held until the responder answers
    // with the matching to_sw_sig level; both sides sample on the same Clk edge.

    logic [WORD_W-1:0] words [NUM_WORDS];
    logic [3:0]        idx;
    logic              wd_run;
    logic              wd_leave;
    logic              wd_expire;

    assign wd_run = (state == START) || (state == REQ) || (state == ACK);

    // Any transition out of a waiting state restarts the watchdog.
    always_comb begin
        wd_leave = abort || wd_expire;
        case (state)
            START:   if (to_sw_sig == SIG_ACK) wd_leave = 1'b1;
            REQ:     if (to_sw_sig == SIG_REQ || to_sw_sig == SIG_START) wd_leave = 1'b1;
            ACK:     if (to_sw_sig == SIG_IDLE || to_sw_sig == SIG_START) wd_leave = 1'b1;
            default: ;
        endcase
    end

    face_rx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (Clk),
        .rst   (Reset),
        .run   (wd_run),
        .clear (wd_leave),
        .expire(wd_expire)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            idx          <= '0;
            to_hw_sig    <= SIG_IDLE;
            packet_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            fmt_err      <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
        end else if (abort) begin
            state        <= IDLE;
            to_hw_sig    <= SIG_IDLE;
            packet_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= START;
                        to_hw_sig    <= SIG_START;
                        busy         <= 1'b1;
                        packet_valid <= 1'b0;
                        timeout_err  <= 1'b0;
                        fmt_err      <= 1'b0;
                        idx          <= '0;
                    end
                end
                START: begin
                    if (wd_expire) begin
                        state       <= ERR;
                        to_hw_sig   <= SIG_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (to_sw_sig == SIG_ACK) begin
                        state     <= REQ;
                        to_hw_sig <= SIG_REQ;
                    end
                end
                REQ: begin
                    if (wd_expire || to_sw_sig == SIG_START) begin
                        state       <= ERR;
                        to_hw_sig   <= SIG_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (to_sw_sig == SIG_REQ) begin
                        words[idx] <= to_sw_port;
                        state      <= ACK;
                        to_hw_sig  <= SIG_ACK;
                    end
                end
                ACK: begin
                    if (wd_expire || to_sw_sig == SIG_START) begin
                        state       <= ERR;
                        to_hw_sig   <= SIG_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (to_sw_sig == SIG_IDLE) begin
                        to_hw_sig <= SIG_REQ;
                        if (idx == 4'(NUM_WORDS - 1)) begin
                            state <= RELEASE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= REQ;
                        end
                    end
                end
                RELEASE: begin
                    // The single extra request cycle lets the responder fall back to idle.
                    state        <= DONE;
                    to_hw_sig    <= SIG_IDLE;
                    busy         <= 1'b0;
                    packet_valid <= 1'b1;
                    fmt_err      <= |words[0][WORD_W-1:6];
                end
                default: begin
                    state     <= IDLE;
                    to_hw_sig <= SIG_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < 4'(NUM_WORDS)) rd_data = words[rd_idx];
    end

    assign face_num   = words[0][5:0];
    assign to_hw_port = '0;

endmodule
